// File: rtl/zed64_pkg.sv
// Shared definitions for the zed64 video subsystem.
// Holds the blitter state encoding, the VRAM geometry defaults and the text-mode row pitch.
// Contents: blt_state_t (BLT_IDLE..BLT_FIN), VRAM_AW, VRAM_DW, TEXT_COLS.
package zed64_pkg;

  localparam int VRAM_AW   = 16;
  localparam int VRAM_DW   = 8;
  localparam int TEXT_COLS = 40;

  typedef enum logic [2:0] {
    BLT_IDLE  = 3'd0,
    BLT_FILL  = 3'd1,
    BLT_CP_RD = 3'd2,
    BLT_CP_WR = 3'd3,
    BLT_FIN   = 3'd4
  } blt_state_t;

endpackage

// File: rtl/vram_addr_gen.sv
// Rectangle address walker: row base plus column counter, wrapping modulo 2^AW.
// Latency: addr is a register; addr_nxt is the value addr takes after a step.
// Backpressure: none; advances only when step is high, reloads on load.
// Ports: load/base/stride/width latch a new rectangle; step advances one byte;
//        addr = current byte, col_last = current byte ends its row,
//        row_last = this step crosses to the next row.
module vram_addr_gen
  import zed64_pkg::*;
#(
  parameter int AW = VRAM_AW
) (
  input  logic          cpu_clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] stride,
  input  logic [7:0]    width,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic [AW-1:0] addr_nxt,
  output logic          col_last,
  output logic          row_last
);

  logic [AW-1:0] row_base_q;
  logic [AW-1:0] stride_q;
  logic [7:0]    width_q;
  logic [7:0]    col_q;

  assign col_last = (col_q == width_q - 8'd1);
  assign row_last = step && col_last;
  // Next row starts at row base + stride, not at addr + 1, so pitch != width works.
  assign addr_nxt = col_last ? row_base_q + stride_q : addr + AW'(1);

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      row_base_q <= '0;
      stride_q   <= '0;
      width_q    <= '0;
      col_q      <= '0;
      addr       <= '0;
    end else if (load) begin
      row_base_q <= base;
      stride_q   <= stride;
      width_q    <= width;
      col_q      <= '0;
      addr       <= base;
    end else if (step) begin
      if (col_last) begin
        row_base_q <= row_base_q + stride_q;
        col_q      <= '0;
      end else begin
        col_q <= col_q + 8'd1;
      end
      addr <= addr_nxt;
    end
  end

endmodule

// File: rtl/vram_blit.sv
// VRAM rectangle fill/copy engine driving dpram port A.
// Latency: first access one cycle after accept; fill 1 byte/cycle, copy 1 byte/2 cycles.
// Backpressure: none; cmd_start is ignored unless idle, busy flags ownership of port A.
// Ports: cmd_* = command (sampled on accepted cmd_start); mem_* = port A;
//        busy = engine owns port A; done = one-cycle completion pulse.
module vram_blit
  import zed64_pkg::*;
#(
  parameter int AW = VRAM_AW,
  parameter int DW = VRAM_DW
) (
  input  logic          cpu_clk,
  input  logic          reset_n,
  input  logic          cmd_start,
  input  logic          cmd_copy,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_src,
  input  logic [7:0]    cmd_width,
  input  logic [7:0]    cmd_height,
  input  logic [AW-1:0] cmd_stride,
  input  logic [DW-1:0] cmd_value,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wena,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          done
);

  blt_state_t    state_q, state_d;
  logic [7:0]    height_q, row_q;
  logic [DW-1:0] wdata_q;

  logic [AW-1:0] addr_d;
  logic          wena_d, busy_d, done_d;
  logic          dst_load, src_load, dst_step, src_step;

  logic [AW-1:0] dst_addr, dst_addr_nxt, src_addr, src_addr_nxt;
  logic          dst_col_last, dst_row_last, src_col_last, src_row_last;
  logic          last_byte;
  logic          src_flags_unused;

  vram_addr_gen #(.AW(AW)) u_dst (
    .cpu_clk  (cpu_clk),
    .reset_n  (reset_n),
    .load     (dst_load),
    .base     (cmd_dst),
    .stride   (cmd_stride),
    .width    (cmd_width),
    .step     (dst_step),
    .addr     (dst_addr),
    .addr_nxt (dst_addr_nxt),
    .col_last (dst_col_last),
    .row_last (dst_row_last)
  );

  vram_addr_gen #(.AW(AW)) u_src (
    .cpu_clk  (cpu_clk),
    .reset_n  (reset_n),
    .load     (src_load),
    .base     (cmd_src),
    .stride   (cmd_stride),
    .width    (cmd_width),
    .step     (src_step),
    .addr     (src_addr),
    .addr_nxt (src_addr_nxt),
    .col_last (src_col_last),
    .row_last (src_row_last)
  );

  // Source walker shares the destination geometry; its end flags are redundant.
  assign src_flags_unused = ^{src_addr_nxt, src_col_last, src_row_last};

  // The destination walker always points at the byte being written this cycle.
  assign last_byte = dst_col_last && (row_q == height_q - 8'd1);

  // Copy data is forwarded straight from the read port: the byte read in CP_RD
  // arrives during CP_WR, and a register stage would cost a third cycle per byte.
  assign mem_wdata = (state_q == BLT_CP_WR) ? mem_rdata : wdata_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = mem_addr;
    wena_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    dst_load = 1'b0;
    src_load = 1'b0;
    dst_step = 1'b0;
    src_step = 1'b0;
    // Outputs are registered, so each branch computes what the bus shows next cycle.
    case (state_q)
      BLT_IDLE: begin
        if (cmd_start) begin
          dst_load = 1'b1;
          src_load = 1'b1;
          busy_d   = 1'b1;
          if (cmd_width == 8'd0 || cmd_height == 8'd0) begin
            state_d = BLT_FIN;
            done_d  = 1'b1;
          end else if (cmd_copy) begin
            state_d = BLT_CP_RD;
            addr_d  = cmd_src;
          end else begin
            state_d = BLT_FILL;
            addr_d  = cmd_dst;
            wena_d  = 1'b1;
          end
        end
      end
      BLT_FILL: begin
        dst_step = 1'b1;
        busy_d   = 1'b1;
        if (last_byte) begin
          state_d = BLT_FIN;
          done_d  = 1'b1;
        end else begin
          addr_d = dst_addr_nxt;
          wena_d = 1'b1;
        end
      end
      BLT_CP_RD: begin
        src_step = 1'b1;
        busy_d   = 1'b1;
        state_d  = BLT_CP_WR;
        addr_d   = dst_addr;
        wena_d   = 1'b1;
      end
      BLT_CP_WR: begin
        dst_step = 1'b1;
        busy_d   = 1'b1;
        if (last_byte) begin
          state_d = BLT_FIN;
          done_d  = 1'b1;
        end else begin
          state_d = BLT_CP_RD;
          addr_d  = src_addr;  // already advanced during CP_RD
        end
      end
      BLT_FIN: begin
        state_d = BLT_IDLE;
      end
      default: begin
        state_d = BLT_IDLE;
      end
    endcase
  end

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BLT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr <= '0;
      mem_wena <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wdata_q  <= '0;
      height_q <= '0;
      row_q    <= '0;
    end else begin
      mem_addr <= addr_d;
      mem_wena <= wena_d;
      busy     <= busy_d;
      done     <= done_d;
      if (dst_load) begin
        wdata_q  <= cmd_value;
        height_q <= cmd_height;
        row_q    <= '0;
      end else if (dst_row_last) begin
        row_q <= row_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vram_blit.sv
// Testbench for vram_blit: synchronous-read VRAM model on port A plus a
// byte-level reference model of fill/copy commands; directed and random commands.
module tb_vram_blit;
  import zed64_pkg::*;

  logic        cpu_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_start = 1'b0;
  logic        cmd_copy = 1'b0;
  logic [15:0] cmd_dst = '0, cmd_src = '0, cmd_stride = '0;
  logic [7:0]  cmd_width = '0, cmd_height = '0, cmd_value = '0;
  logic [15:0] mem_addr;
  logic        mem_wena;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy, done;

  always #5 cpu_clk = ~cpu_clk;

  vram_blit #(.AW(16), .DW(8)) dut (
    .cpu_clk    (cpu_clk),
    .reset_n    (reset_n),
    .cmd_start  (cmd_start),
    .cmd_copy   (cmd_copy),
    .cmd_dst    (cmd_dst),
    .cmd_src    (cmd_src),
    .cmd_width  (cmd_width),
    .cmd_height (cmd_height),
    .cmd_stride (cmd_stride),
    .cmd_value  (cmd_value),
    .mem_addr   (mem_addr),
    .mem_wena   (mem_wena),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done)
  );

  // VRAM port A: write on the edge, registered read data one cycle later.
  logic [7:0] vram    [0:65535];
  logic [7:0] ref_mem [0:65535];
  int cyc = 0;
  int ram_writes = 0;

  always @(posedge cpu_clk) begin
    cyc <= cyc + 1;
    if (mem_wena) begin
      vram[mem_addr] <= mem_wdata;
      ram_writes     <= ram_writes + 1;
    end
    mem_rdata <= vram[mem_addr];
  end

  typedef struct {
    int          edge_n;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t wr_q[$];
  wr_t exp_q[$];
  int  done_q[$];
  int  busy_cnt = 0;
  int  t0 = 0;
  int  exp_done = 0;
  int  exp_busy = 0;

  // Observe outputs mid-cycle; an access seen now lands on edge cyc+1.
  always @(negedge cpu_clk) begin
    if (reset_n) begin
      if (mem_wena) wr_q.push_back('{edge_n: cyc + 1, addr: mem_addr, data: mem_wdata});
      if (done) done_q.push_back(cyc + 1);
      if (busy) busy_cnt++;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    vram[a] <= d;
    ref_mem[a] = d;
  endtask

  // Drive one command strobe; afterwards scramble cmd_* to prove they were latched.
  task automatic issue(input bit cp, input logic [15:0] dst, input logic [15:0] src,
                       input logic [7:0] w, input logic [7:0] h,
                       input logic [15:0] stride, input logic [7:0] val);
    wr_q.delete();
    done_q.delete();
    busy_cnt = 0;
    @(negedge cpu_clk);
    cmd_copy   = cp;
    cmd_dst    = dst;
    cmd_src    = src;
    cmd_width  = w;
    cmd_height = h;
    cmd_stride = stride;
    cmd_value  = val;
    cmd_start  = 1'b1;
    t0 = cyc + 1;
    @(negedge cpu_clk);
    cmd_start  = 1'b0;
    cmd_copy   = 1'($urandom);
    cmd_dst    = 16'($urandom);
    cmd_src    = 16'($urandom);
    cmd_width  = 8'($urandom);
    cmd_height = 8'($urandom);
    cmd_stride = 16'($urandom);
    cmd_value  = 8'($urandom);
  endtask

  // Reference: bytes in row-major ascending order, each copy byte read from the
  // memory state left by all earlier writes (forward smear on overlap).
  task automatic model(input bit cp, input logic [15:0] dst, input logic [15:0] src,
                       input logic [7:0] w, input logic [7:0] h,
                       input logic [15:0] stride, input logic [7:0] val);
    int k;
    int n;
    logic [15:0] da, sa;
    logic [7:0] d;
    k = 0;
    exp_q.delete();
    n = int'(w) * int'(h);
    for (int r = 0; r < int'(h); r++) begin
      for (int c = 0; c < int'(w); c++) begin
        k++;
        da = 16'(int'(dst) + r * int'(stride) + c);
        sa = 16'(int'(src) + r * int'(stride) + c);
        d  = cp ? ref_mem[sa] : val;
        ref_mem[da] = d;
        exp_q.push_back('{edge_n: cp ? t0 + 2 * k : t0 + k, addr: da, data: d});
      end
    end
    if (n == 0)  exp_done = t0 + 1;
    else if (cp) exp_done = t0 + 2 * n + 1;
    else         exp_done = t0 + n + 1;
    exp_busy = exp_done - t0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      #1;
      if (done_q.size() != 0) break;
      @(negedge cpu_clk);
    end
  endtask

  task automatic verify(input string name);
    int diffs;
    check({name, "/n_writes"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
      check({name, "/wr_edge"}, wr_q[i].edge_n - t0, exp_q[i].edge_n - t0);
      check({name, "/wr_addr"}, wr_q[i].addr, exp_q[i].addr);
      check({name, "/wr_data"}, wr_q[i].data, exp_q[i].data);
    end
    check({name, "/done_cnt"}, done_q.size(), 1);
    if (done_q.size() > 0) check({name, "/done_edge"}, done_q[0] - t0, exp_done - t0);
    check({name, "/busy_cycles"}, busy_cnt, exp_busy);
    diffs = 0;
    for (int a = 0; a < 65536; a++) if (vram[a] !== ref_mem[a]) diffs++;
    check({name, "/vram_diffs"}, diffs, 0);
  endtask

  task automatic run_cmd(input string name, input bit cp, input logic [15:0] dst,
                         input logic [15:0] src, input logic [7:0] w, input logic [7:0] h,
                         input logic [15:0] stride, input logic [7:0] val);
    issue(cp, dst, src, w, h, stride, val);
    model(cp, dst, src, w, h, stride, val);
    wait_done(2 * int'(w) * int'(h) + 10);
    verify(name);
  endtask

  initial begin
    bit          cp;
    logic [15:0] dst, src, stride;
    logic [7:0]  w, h, val;
    int          snap, hits, nw;

    for (int i = 0; i < 65536; i++) poke(16'(i), 8'($urandom));

    repeat (3) @(negedge cpu_clk);
    #1;
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_wena", mem_wena, 1'b0);
    check("rst_mem_wdata", mem_wdata, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge cpu_clk);
    reset_n = 1'b1;

    run_cmd("fill", 1'b0, 16'h0400, 16'h0000, 8'd4, 8'd2, 16'(TEXT_COLS), 8'h20);
    check("fill_0x042b", vram[16'h042B], 8'h20);

    poke(16'h1000, 8'hA1);
    poke(16'h1001, 8'hA2);
    poke(16'h1002, 8'hA3);
    run_cmd("copy", 1'b1, 16'h2000, 16'h1000, 8'd3, 8'd1, 16'(TEXT_COLS), 8'h00);
    check("copy_0x2002", vram[16'h2002], 8'hA3);

    run_cmd("zero", 1'b0, 16'h0800, 16'h0000, 8'd0, 8'd5, 16'd40, 8'h11);
    run_cmd("wrap", 1'b0, 16'hFFFE, 16'h0000, 8'd4, 8'd1, 16'd40, 8'h55);
    check("wrap_0x0001", vram[16'h0001], 8'h55);

    // A second start in the middle of a fill must be dropped entirely.
    issue(1'b0, 16'h0500, 16'h0000, 8'd8, 8'd1, 16'd40, 8'h77);
    model(1'b0, 16'h0500, 16'h0000, 8'd8, 8'd1, 16'd40, 8'h77);
    @(negedge cpu_clk);
    cmd_copy   = 1'b0;
    cmd_dst    = 16'h3000;
    cmd_width  = 8'd1;
    cmd_height = 8'd1;
    cmd_start  = 1'b1;
    @(negedge cpu_clk);
    cmd_start  = 1'b0;
    wait_done(30);
    repeat (4) @(negedge cpu_clk);
    #1;
    verify("ignore");
    hits = 0;
    foreach (wr_q[i]) if (wr_q[i].addr == 16'h3000) hits++;
    check("ignore_0x3000_hits", hits, 0);

    // Reset while the third byte of an 8-byte fill is on the bus.
    snap = ram_writes;
    issue(1'b0, 16'h0600, 16'h0000, 8'd8, 8'd1, 16'd40, 8'hC3);
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_wena", mem_wena, 1'b0);
    check("midrst_busy", busy, 1'b0);
    repeat (3) @(negedge cpu_clk);
    #1;
    nw = ram_writes - snap;
    check("midrst_writes_2_to_3", (nw >= 2 && nw <= 3) ? 1 : 0, 1);
    check("midrst_done_cnt", done_q.size(), 0);
    for (int k = 0; k < nw && k < 8; k++) ref_mem[16'h0600 + 16'(k)] = 8'hC3;
    hits = 0;
    for (int a = 0; a < 65536; a++) if (vram[a] !== ref_mem[a]) hits++;
    check("midrst_vram_diffs", hits, 0);
    reset_n = 1'b1;
    run_cmd("after_rst", 1'b0, 16'h0700, 16'h0000, 8'd5, 8'd2, 16'd40, 8'h3C);

    // Random back-to-back commands, including overlapping forward copies.
    for (int i = 0; i < 10; i++) begin
      cp     = 1'($urandom);
      w      = 8'($urandom_range(0, 12));
      h      = 8'($urandom_range(0, 5));
      stride = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 80));
      dst    = 16'($urandom);
      src    = (i % 3 == 0) ? dst - 16'd1 : 16'($urandom);
      val    = 8'($urandom);
      run_cmd("random", cp, dst, src, w, h, stride, val);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_blit.md
# vram_blit

Rectangle fill/copy engine on the CPU clock domain. It writes character and colour data into video RAM through dpram port A, the side opposite the video controller's read-only port B. The CPU issues a single command (destination, size, stride, fill value or source) and the engine generates the byte writes, so software does not have to loop over `cpu_addr`. While `busy` is high, an external mux gives port A to this block.

## Interface
Parameters:
- `AW`, 16, VRAM byte address width.
- `DW`, 8, VRAM data width.

Ports:
- `cpu_clk`  in  1  system clock; 100 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_start`  in  1  one-cycle command strobe; sampled only in IDLE.
- `cmd_copy`  in  1  0 = fill with `cmd_value`; 1 = copy from `cmd_src`.
- `cmd_dst`  in  AW  destination top-left byte address.
- `cmd_src`  in  AW  source top-left byte address (copy only).
- `cmd_width`  in  8  bytes per row.
- `cmd_height`  in  8  number of rows.
- `cmd_stride`  in  AW  row pitch, applied to both destination and source.
- `cmd_value`  in  DW  fill byte.
- `mem_addr`  out  AW  port A address.
- `mem_wena`  out  1  port A write enable.
- `mem_wdata`  out  DW  port A write data.
- `mem_rdata`  in  DW  port A read data; valid 1 cycle after `mem_addr` is presented.
- `busy`  out  1  high from the cycle after accept until `done`.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, FILL, CP_RD, CP_WR, FIN.
- IDLE, `cmd_start`=1:
  - Latch every `cmd_*` input.
  - If width=0 or height=0, go to FIN.
  - Otherwise go to FILL (`cmd_copy`=0) or CP_RD (`cmd_copy`=1).
- FILL:
  - Each cycle: `mem_addr`=current destination, `mem_wena`=1, `mem_wdata`=latched value.
  - Advance column. At the last column, add stride to the destination row base and reset the column.
  - After the last byte of the last row, go to FIN.
- CP_RD: `mem_addr`=current source, `mem_wena`=0; then go to CP_WR.
- CP_WR: `mem_addr`=current destination, `mem_wena`=1, `mem_wdata`=`mem_rdata`; advance both pointers; go to CP_RD, or to FIN after the last byte.
- FIN: `done`=1 for one cycle, `busy` drops in the same cycle, then return to IDLE.
- Address arithmetic is modulo 2^AW. Row base = dst + row×stride and col = 0..width−1, all summed with a wrapping AW-bit add.
- Copies always run forward: row-major, ascending. With overlapping regions and dst>src, the result is the defined byte-by-byte smear; no memmove semantics.
- `cmd_start` while not in IDLE is ignored and has no side effects.
- `mem_wena` is never asserted outside FILL and CP_WR.

## Timing
- Reset values: `mem_addr`=0, `mem_wena`=0, `mem_wdata`=0, `busy`=0, `done`=0, state IDLE, and all latched fields 0.
- All outputs are registered.
- Start is accepted at edge T0. The first write (fill) or read (copy) appears at T0+1.
- Fill throughput is 1 byte per cycle with no gap at row boundaries. N=W×H writes occupy T0+1..T0+N, and `done` is at T0+N+1.
- Copy throughput is 1 byte per 2 cycles. Writes fall at T0+2k for k=1..N, and `done` is at T0+2N+1.
- Zero-size command: `done` at T0+1 with no write.
- Asserting `reset_n` low at any time aborts immediately. `mem_wena` drops asynchronously, and no `done` is issued.
- Back-to-back: a new `cmd_start` can be accepted in the cycle after `done`.

## Structure
- Shared package `zed64_pkg` holds:
  - state encoding constants (`BLT_IDLE`..`BLT_FIN`);
  - `VRAM_AW`/`VRAM_DW` defaults;
  - `TEXT_COLS` = 40, the default stride used by software.
- One sub-module, `vram_addr_gen`, instantiated twice (destination and source):
  - holds the row base and column counter;
  - inputs: load, base, stride, width, step;
  - outputs: addr and row_last/col_last flags.
- Row count and the FSM stay in `vram_blit`.

## Test plan
- Fill: dst 0x0400, W=4, H=2, stride 40, value 0x20 -> writes 0x20 to 0x0400–0x0403 then 0x0428–0x042B on consecutive cycles T0+1..T0+8; `done` at T0+9; VRAM model otherwise unchanged.
- Copy: preload 0x1000..0x1002 = 0xA1,0xA2,0xA3; src 0x1000, dst 0x2000, W=3, H=1 -> 0x2000..0x2002 = 0xA1..0xA3; writes at T0+2/4/6; `done` at T0+7.
- Zero size: W=0, H=5 -> no `mem_wena`; `done` at T0+1; `busy` high for that one cycle only.
- Wrap: fill dst 0xFFFE, W=4, H=1, value 0x55 -> writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Busy/ignore: second `cmd_start` (dst 0x3000) during a W=8 fill -> no write ever touches 0x3000; exactly one `done`.
- Reset mid-op: drop `reset_n` at the third write of an 8-byte fill -> `mem_wena`=0 immediately; no `done`; only 2–3 bytes written; a fresh command after release runs normally.
